cbm2_bus_sched: RTL and testbench

Bus cycle scheduler for the CBM-II system bus. It divides `clk_sys` into 6509 bus cycles and time-slices each cycle into a video half and a CPU half, driving the `cpuCycle`/`vidCycle`/`vicPhase` strobes consumed by the bus logic. On P2 (Professional) models it also runs the VIC cycle-steal handshake (BA → RDY, 3-cycle grace, AEC). It sits between the clock/reset logic and the bus decoder, the CPU clock enable, and the VIC.

---
 rtl/cbm2_bus_sched.sv | 116 +++++++++++
 tb/tb_cbm2_bus_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cbm2_bus_sched.sv
// CBM-II bus cycle scheduler: slices clk_sys into 6509 bus cycles with video/CPU halves
// and runs the P2 VIC cycle-steal handshake (BA -> RDY, three grace cycles, AEC).
module cbm2_bus_sched #(
  parameter int CLK_DIV  = 32,
  parameter int SLOT_LEN = 6
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       model,
  input  logic                       vic_ba,
  input  logic                       cpu_rnw,
  output logic                       vicPhase,
  output logic                       vidCycle,
  output logic                       cpuCycle,
  output logic                       ram_we,
  output logic                       cpu_ce,
  output logic                       cpu_rdy,
  output logic                       vic_aec,
  output logic [$clog2(CLK_DIV)-1:0] cyc_pos
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF   = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] VID_LO = CW'(1);
  localparam logic [CW-1:0] VID_HI = CW'(SLOT_LEN);
  localparam logic [CW-1:0] CPU_LO = CW'(CLK_DIV / 2 + 1);
  localparam logic [CW-1:0] CPU_HI = CW'(CLK_DIV / 2 + SLOT_LEN);

  typedef enum logic [2:0] {ST_CPU, ST_G1, ST_G2, ST_G3, ST_VIC} steal_e;

  steal_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic          model_q, model_d;
  logic          vid_q, vid_d;
  logic          cpu_q, cpu_d;
  logic          ce_q, ce_d;
  logic          rdy_q, rdy_d;
  logic          aec_q, aec_d;
  logic          boundary;
  logic          in_vid, in_cpu;

  // run_q holds the counter at 0 for the first edge after reset release.
  assign boundary = run_q && (cnt_q == LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d   = cnt_q;
    state_d = state_q;
    model_d = model_q;
    if (run_q) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    if (boundary) begin
      model_d = model;
      // The newly sampled model also releases the bus at this same boundary.
      if (model || vic_ba) begin
        state_d = ST_CPU;
      end else begin
        case (state_q)
          ST_CPU:  state_d = ST_G1;
          ST_G1:   state_d = ST_G2;
          ST_G2:   state_d = ST_G3;
          ST_G3:   state_d = ST_VIC;
          ST_VIC:  state_d = ST_VIC;
          default: state_d = ST_CPU;
        endcase
      end
    end
  end

  // Strobes are registered from the next count so they line up exactly with cnt.
  always_comb begin
    rdy_d  = (state_d == ST_CPU);
    aec_d  = (state_d != ST_VIC);
    in_vid = (cnt_d >= VID_LO) && (cnt_d <= VID_HI);
    in_cpu = (cnt_d >= CPU_LO) && (cnt_d <= CPU_HI);
    vid_d  = !model_d && (in_vid || (in_cpu && !aec_d));
    cpu_d  = in_cpu && aec_d;
    ce_d   = (cnt_d == LAST) && aec_d;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      state_q <= ST_CPU;
      model_q <= 1'b0;
      vid_q   <= 1'b0;
      cpu_q   <= 1'b0;
      ce_q    <= 1'b0;
      rdy_q   <= 1'b1;
      aec_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      state_q <= state_d;
      model_q <= model_d;
      vid_q   <= vid_d;
      cpu_q   <= cpu_d;
      ce_q    <= ce_d;
      rdy_q   <= rdy_d;
      aec_q   <= aec_d;
    end
  end

  assign vicPhase = (cnt_q >= HALF);
  assign vidCycle = vid_q;
  assign cpuCycle = cpu_q;
  assign ram_we   = cpu_q && !cpu_rnw;
  assign cpu_ce   = ce_q;
  assign cpu_rdy  = rdy_q;
  assign vic_aec  = aec_q;
  assign cyc_pos  = cnt_q;

endmodule

// File: tb/tb_cbm2_bus_sched.sv
// Scoreboard bench for cbm2_bus_sched (CLK_DIV=32, SLOT_LEN=6): stimulus pushes the
// expected outputs for each clock, a negedge monitor pops and compares them.
module tb_cbm2_bus_sched;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       model   = 1'b0;
  logic       vic_ba  = 1'b1;
  logic       cpu_rnw = 1'b1;
  logic       vicPhase, vidCycle, cpuCycle, ram_we, cpu_ce, cpu_rdy, vic_aec;
  logic [4:0] cyc_pos;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    int         c;
    logic       vid, cpu, we, ce, ph, rdy, aec;
    logic [4:0] pos;
  } exp_t;

  exp_t exp_q[$];

  cbm2_bus_sched #(.CLK_DIV(32), .SLOT_LEN(6)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .model   (model),
    .vic_ba  (vic_ba),
    .cpu_rnw (cpu_rnw),
    .vicPhase(vicPhase),
    .vidCycle(vidCycle),
    .cpuCycle(cpuCycle),
    .ram_we  (ram_we),
    .cpu_ce  (cpu_ce),
    .cpu_rdy (cpu_rdy),
    .vic_aec (vic_aec),
    .cyc_pos (cyc_pos)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs at bus-cycle position c, given the model/steal state of that cycle.
  task automatic push_exp(input string tag, input int c, input bit mq, input bit rdy,
                          input bit aec, input bit rnw);
    exp_t e;
    bit   vid_slot, cpu_slot;
    vid_slot = (c >= 1) && (c <= 6);
    cpu_slot = (c >= 17) && (c <= 22);
    e.tag = tag;
    e.c   = c;
    e.vid = !mq && (vid_slot || (cpu_slot && !aec));
    e.cpu = cpu_slot && aec;
    e.we  = cpu_slot && aec && !rnw;
    e.ce  = aec && (c == 31);
    e.ph  = (c >= 16);
    e.rdy = rdy;
    e.aec = aec;
    e.pos = 5'(c);
    exp_q.push_back(e);
  endtask

  task automatic push_reset(input string tag);
    exp_t e;
    e.tag = tag;
    e.c   = 0;
    e.vid = 1'b0;
    e.cpu = 1'b0;
    e.we  = 1'b0;
    e.ce  = 1'b0;
    e.ph  = 1'b0;
    e.rdy = 1'b1;
    e.aec = 1'b1;
    e.pos = 5'd0;
    exp_q.push_back(e);
  endtask

  // Drives one bus cycle from position 0 up to stop_at-1; ba is forced low at pulse_pos.
  task automatic run_cycle(input string tag, input bit mq, input bit rdy, input bit aec,
                           input bit ba, input bit rnw, input bit mdl,
                           input int pulse_pos, input int stop_at);
    for (int c = 0; c < stop_at; c++) begin
      vic_ba  = (c == pulse_pos) ? 1'b0 : ba;
      cpu_rnw = rnw;
      model   = mdl;
      push_exp(tag, c, mq, rdy, aec, rnw);
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Leaves the bench at position 0 of the first counting bus cycle.
  task automatic release_reset();
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(posedge clk_sys);
    #1;
  endtask

  always @(negedge clk_sys) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("%s vidCycle cnt=%0d", e.tag, e.c), {7'd0, vidCycle}, {7'd0, e.vid});
      check($sformatf("%s cpuCycle cnt=%0d", e.tag, e.c), {7'd0, cpuCycle}, {7'd0, e.cpu});
      check($sformatf("%s ram_we cnt=%0d",   e.tag, e.c), {7'd0, ram_we},   {7'd0, e.we});
      check($sformatf("%s cpu_ce cnt=%0d",   e.tag, e.c), {7'd0, cpu_ce},   {7'd0, e.ce});
      check($sformatf("%s vicPhase cnt=%0d", e.tag, e.c), {7'd0, vicPhase}, {7'd0, e.ph});
      check($sformatf("%s cpu_rdy cnt=%0d",  e.tag, e.c), {7'd0, cpu_rdy},  {7'd0, e.rdy});
      check($sformatf("%s vic_aec cnt=%0d",  e.tag, e.c), {7'd0, vic_aec},  {7'd0, e.aec});
      check($sformatf("%s cyc_pos cnt=%0d",  e.tag, e.c), {3'd0, cyc_pos},  {3'd0, e.pos});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 push_reset("reset");
    release_reset();

    // Professional model, idle bus: video slot 1-6, CPU slot 17-22, cpu_ce at 31.
    //        tag          mq rdy aec ba rnw mdl pulse stop
    run_cycle("idle0",     0, 1,  1,  1, 1,  0,  -1,   32);
    run_cycle("idle1",     0, 1,  1,  1, 1,  0,  -1,   32);
    run_cycle("write",     0, 1,  1,  1, 0,  0,  -1,   32);

    // BA low away from the boundary is ignored.
    run_cycle("ba_pulse",  0, 1,  1,  1, 1,  0,  10,   32);
    run_cycle("post_pls",  0, 1,  1,  1, 1,  0,  -1,   32);

    // Full steal: ba low from cycle N, AEC drops in N+4, released on ba high.
    run_cycle("steal_n",   0, 1,  1,  0, 1,  0,  -1,   32);
    run_cycle("steal_g1",  0, 0,  1,  0, 1,  0,  -1,   32);
    run_cycle("steal_g2",  0, 0,  1,  0, 0,  0,  -1,   32);
    run_cycle("steal_g3",  0, 0,  1,  0, 1,  0,  -1,   32);
    run_cycle("steal_vic", 0, 0,  0,  0, 0,  0,  -1,   32);
    run_cycle("vic_rel",   0, 0,  0,  1, 0,  0,  -1,   32);
    run_cycle("cpu_back",  0, 1,  1,  1, 1,  0,  -1,   32);

    // Reset asserted at cnt 19 while in G2.
    run_cycle("r_n",       0, 1,  1,  0, 1,  0,  -1,   32);
    run_cycle("r_g1",      0, 0,  1,  0, 1,  0,  -1,   32);
    run_cycle("r_g2",      0, 0,  1,  0, 1,  0,  -1,   19);
    push_exp("r_g2", 19, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk_sys);
    #1 reset_n = 1'b0;
    #1 push_reset("mid_reset");
    vic_ba = 1'b1;
    @(negedge clk_sys);
    release_reset();
    run_cycle("post_rst",  0, 1,  1,  1, 1,  0,  -1,   32);

    // Business model: switching to 1 in G2 releases the bus at that boundary.
    run_cycle("m_a",       0, 1,  1,  0, 1,  0,  -1,   32);
    run_cycle("m_g1",      0, 0,  1,  0, 1,  0,  -1,   32);
    run_cycle("m_g2",      0, 0,  1,  0, 1,  1,  -1,   32);
    run_cycle("m_bus1",    1, 1,  1,  0, 1,  1,  -1,   32);
    run_cycle("m_bus2",    1, 1,  1,  0, 0,  1,  -1,   32);
    run_cycle("m_bus3",    1, 1,  1,  0, 1,  1,  -1,   32);
    run_cycle("m_back",    1, 1,  1,  1, 1,  0,  -1,   32);
    run_cycle("m_pro",     0, 1,  1,  1, 1,  0,  -1,   32);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_sys);
    #1;
    check("scoreboard drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
